// File: rtl/fewcore_pkg.sv
// rtl/fewcore_pkg.sv - shared fewcore opcode, funct3 and memory-stage definitions
package fewcore_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        ERR
    } mem_state_t;

    // op is {funct3, opcode}
    function automatic logic is_load_op(input logic [9:0] op);
        return (op[6:0] == OPC_LOAD) &&
               (op[9:7] == F3_B  || op[9:7] == F3_H || op[9:7] == F3_W ||
                op[9:7] == F3_BU || op[9:7] == F3_HU);
    endfunction

    function automatic logic is_store_op(input logic [9:0] op);
        return (op[6:0] == OPC_STORE) &&
               (op[9:7] == F3_B || op[9:7] == F3_H || op[9:7] == F3_W);
    endfunction

    // funct3[1:0] encodes access size for both signed and unsigned loads
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return !offset[0];
            2'b10:   return offset == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane steering and left-justified load extraction
module mem_lane_align
    import fewcore_pkg::*;
(
    input  logic [2:0]  store_funct3,
    input  logic [1:0]  store_offset,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_offset,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (store_funct3)
            F3_B: begin
                be    = 4'b0001 << store_offset;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                be    = store_offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // The downstream extender expects the selected lane in the top bits
    always_comb begin
        load_data = rdata;
        case (load_funct3)
            F3_B, F3_BU: load_data = {rdata[8*load_offset +: 8], 24'b0};
            F3_H, F3_HU: load_data = {(load_offset[1] ? rdata[31:16] : rdata[15:0]), 16'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32I memory-access stage with req/ack data-memory handshake
module mem_access
    import fewcore_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [11:0]     operation,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic            flush,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [31:0]     mem_wdata,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata,
    output logic            stall,
    output logic [31:0]     memData,
    output logic            load_valid,
    output logic            misaligned,
    output logic            bus_error
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    mem_state_t    state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    funct3_q;
    logic [1:0]    offset_q;
    logic          load_q;
    logic          flushed_q;

    logic [2:0]    funct3;
    logic          op_load;
    logic          op_store;
    logic          aligned;
    logic          idle_op;
    logic          accept;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   ld_data;
    logic          unused_funct;

    assign funct3       = operation[9:7];
    assign op_load      = is_load_op(operation[9:0]);
    assign op_store     = is_store_op(operation[9:0]);
    assign aligned      = is_aligned(funct3, addr[1:0]);
    assign unused_funct = ^operation[11:10];

    // A flushed instruction neither starts an access nor raises a fault
    assign idle_op    = !reset && (state == IDLE) && valid_in && !flush && (op_load || op_store);
    assign accept     = idle_op && aligned;
    assign misaligned = idle_op && !aligned;
    assign stall      = !reset && ((state == BUSY) || accept);

    mem_lane_align u_lane_align (
        .store_funct3 (funct3),
        .store_offset (addr[1:0]),
        .store_data   (store_data[31:0]),
        .be           (st_be),
        .wdata        (st_wdata),
        .load_funct3  (funct3_q),
        .load_offset  (offset_q),
        .rdata        (mem_rdata),
        .load_data    (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            memData    <= '0;
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
            wait_cnt   <= '0;
            funct3_q   <= '0;
            offset_q   <= '0;
            load_q     <= 1'b0;
            flushed_q  <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= op_store;
                        mem_addr  <= {addr[XLEN-1:2], 2'b00};
                        mem_be    <= op_store ? st_be : 4'b1111;
                        mem_wdata <= op_store ? st_wdata : 32'b0;
                        funct3_q  <= funct3;
                        offset_q  <= addr[1:0];
                        load_q    <= op_load;
                        flushed_q <= 1'b0;
                        wait_cnt  <= '0;
                    end
                end
                BUSY: begin
                    // The bus transaction cannot be abandoned; flush only hides the result
                    if (flush) begin
                        flushed_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (load_q && !flushed_q && !flush) begin
                            memData    <= ld_data;
                            load_valid <= 1'b1;
                        end
                    end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                        state     <= ERR;
                        mem_req   <= 1'b0;
                        bus_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
